// File: rtl/dmem_sized_port.sv
// Data memory with byte/halfword/word access, valid/ready handshake and a
// registered one-cycle response carrying the load result or an error flag.
module dmem_sized_port #(
    parameter int unsigned    AW          = 32,
    parameter int unsigned    DEPTH_WORDS = 480,
    parameter logic [AW-1:0]  BASE_ADDR   = 32'h1001_0000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [1:0]    req_size,
    input  logic          req_unsigned,
    input  logic [AW-1:0] address,
    input  logic [31:0]   writeData,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [31:0]   readData,
    output logic          resp_error
);

    localparam int unsigned   IW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [AW-1:0] LIMIT = AW'(4 * DEPTH_WORDS);

    typedef enum logic {IDLE, RESP} state_t;

    state_t        state, state_nxt;
    logic          accept;
    logic [AW-1:0] off;
    logic [1:0]    lane;
    logic [IW-1:0] widx;
    logic          acc_err;
    logic [3:0]    be;
    logic [31:0]   wdata_rep;
    logic [31:0]   rword;
    logic [31:0]   rdata_p1;
    logic          err_p1;

    logic [31:0]   mem [DEPTH_WORDS];

    function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] ln);
        case (size)
            2'b00:   return 4'b0001 << ln;
            2'b01:   return ln[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] ln, input logic uns);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] ext;
        b = word[8*ln +: 8];
        h = ln[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00: begin
                ext = b;
                return uns ? {24'd0, b} : ext;
            end
            2'b01: begin
                ext = h;
                return uns ? {16'd0, h} : ext;
            end
            default: return word;
        endcase
    endfunction

    assign accept = req_valid & req_ready;
    assign off    = address - BASE_ADDR;
    assign lane   = off[1:0];
    assign widx   = off[IW+1:2];

    // Range check uses the full offset, so the word index is only trusted when acc_err is clear.
    always_comb begin
        acc_err = 1'b0;
        if (address < BASE_ADDR)                   acc_err = 1'b1;
        if (off >= LIMIT)                          acc_err = 1'b1;
        if (req_size == 2'b11)                     acc_err = 1'b1;
        if (req_size == 2'b01 && lane[0])          acc_err = 1'b1;
        if (req_size == 2'b10 && lane != 2'b00)    acc_err = 1'b1;
    end

    always_comb begin
        be        = lane_enables(req_size, lane);
        wdata_rep = (req_size == 2'b00) ? {4{writeData[7:0]}} :
                    (req_size == 2'b01) ? {2{writeData[15:0]}} : writeData;
        rword     = acc_err ? 32'd0 : mem[widx];
    end

    always_ff @(posedge clk) begin
        if (accept && req_write && !acc_err && !reset) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[widx][8*i +: 8] <= wdata_rep[8*i +: 8];
            end
        end
    end

    // Stage p1: response registered at the accept edge
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_p1 <= 32'd0;
            err_p1   <= 1'b0;
        end else if (accept) begin
            err_p1   <= acc_err;
            rdata_p1 <= (acc_err || req_write) ? 32'd0
                        : extend_load(rword, req_size, lane, req_unsigned);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)     state_nxt = RESP;
            RESP:    if (resp_ready) state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = (state == RESP);
    end

    assign readData   = rdata_p1;
    assign resp_error = err_p1;

endmodule
